// File: rtl/pwm_pkg.sv
// Shared PWM link definitions: parameter defaults, width derivations, FSM states.
// Latency: none (package only).
// Backpressure: none; used by the serializer and the deserializer alike.
package pwm_pkg;

  localparam int PULSE_FREQ_DEF = 1;
  localparam int SYS_FREQ_DEF   = 100;
  localparam int PERIOD_TOL_DEF = 2;

  typedef enum logic [1:0] {
    S_ACQ  = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } pwm_state_e;

  // Clock cycles in one nominal PWM period.
  function automatic int pulse_window(input int sys_freq, input int pulse_freq);
    return sys_freq / pulse_freq;
  endfunction

  // Longest run without an edge before the link is treated as a static level.
  function automatic int timeout_cycles(input int sys_freq, input int pulse_freq);
    return 2 * (sys_freq / pulse_freq);
  endfunction

  localparam int PULSE_WINDOW_DEF = pulse_window(SYS_FREQ_DEF, PULSE_FREQ_DEF);
  localparam int TIMEOUT_DEF      = timeout_cycles(SYS_FREQ_DEF, PULSE_FREQ_DEF);
  localparam int DUTY_BITS_DEF    = $clog2(PULSE_WINDOW_DEF + 1);
  localparam int CNT_BITS_DEF     = $clog2(TIMEOUT_DEF + 1);

endpackage

// File: rtl/pwm_deserializer_if.sv
// PWM receive bundle: incoming wire plus the recovered duty measurement.
// Latency: none (wires only).
// Backpressure: none; duty_valid/period_err are single-cycle strobes.
interface pwm_deserializer_if #(
  parameter int DUTY_BITS = pwm_pkg::DUTY_BITS_DEF
);
  logic                 pwm_in;
  logic [DUTY_BITS-1:0] duty_cycle;
  logic                 duty_valid;
  logic                 period_err;
  logic                 locked;

  // Side that drives the wire and consumes measurements.
  modport master (output pwm_in, input duty_cycle, duty_valid, period_err, locked);
  // Measuring side.
  modport slave  (input pwm_in, output duty_cycle, duty_valid, period_err, locked);
endinterface

// File: rtl/pwm_edge_sync.sv
// Two-flop synchronizer for the asynchronous PWM wire plus edge detection.
// Latency: level valid 2 cycles after sampling; rise/fall combinational off s2/s3.
// Backpressure: none; free-running every clock.
module pwm_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);
  logic s1, s2, s3;

  // Metastability filter (s1->s2) and one-cycle history (s3) for edge detect.
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~s3;
  assign fall  = ~s2 & s3;
endmodule

// File: rtl/pwm_deserializer.sv
// Recovers PWM duty as a high-time count per period and validates the period.
// Latency: results visible 3 edges after the wire edge that closes a period.
// Backpressure: none; strobes are single-cycle and must be captured by the consumer.
module pwm_deserializer
  import pwm_pkg::*;
#(
  parameter int PULSE_FREQ = PULSE_FREQ_DEF,
  parameter int SYS_FREQ   = SYS_FREQ_DEF,
  parameter int PERIOD_TOL = PERIOD_TOL_DEF
) (
  input logic               clk,
  input logic               reset,
  pwm_deserializer_if.slave bus
);
  localparam int PULSE_WINDOW = pulse_window(SYS_FREQ, PULSE_FREQ);
  localparam int TIMEOUT      = timeout_cycles(SYS_FREQ, PULSE_FREQ);
  localparam int DUTY_BITS    = $clog2(PULSE_WINDOW + 1);
  localparam int CNT_BITS     = $clog2(TIMEOUT + 1);

  localparam logic [CNT_BITS-1:0]  PW_C  = CNT_BITS'(PULSE_WINDOW);
  localparam logic [CNT_BITS-1:0]  TO_C  = CNT_BITS'(TIMEOUT);
  localparam logic [CNT_BITS-1:0]  LO_C  = CNT_BITS'(PULSE_WINDOW - PERIOD_TOL);
  localparam logic [CNT_BITS-1:0]  HI_C  = CNT_BITS'(PULSE_WINDOW + PERIOD_TOL);
  localparam logic [CNT_BITS-1:0]  ONE_C = CNT_BITS'(1);
  localparam logic [DUTY_BITS-1:0] PW_D  = DUTY_BITS'(PULSE_WINDOW);

  logic level, rise, fall;

  pwm_edge_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .din   (bus.pwm_in),
    .level (level),
    .rise  (rise),
    .fall  (fall)
  );

  pwm_state_e           state_q, state_d;
  logic [CNT_BITS-1:0]  period_q, period_d;
  logic [CNT_BITS-1:0]  high_q, high_d;
  logic [DUTY_BITS-1:0] duty_q, duty_d;
  logic                 valid_q, valid_d;
  logic                 err_q, err_d;
  logic                 locked_q, locked_d;

  logic [CNT_BITS-1:0] period_nxt, period_inc, high_inc, high_clamped;

  assign period_nxt   = period_q + ONE_C;
  assign period_inc   = (period_q == TO_C) ? TO_C : period_nxt;
  assign high_inc     = (high_q == TO_C) ? TO_C : high_q + ONE_C;
  assign high_clamped = (high_q > PW_C) ? PW_C : high_q;

  // State and measurement registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_ACQ;
      period_q <= '0;
      high_q   <= '0;
      duty_q   <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      high_q   <= high_d;
      duty_q   <= duty_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      locked_q <= locked_d;
    end
  end

  // Period/high-time tracking, period validation and publish decisions.
  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    high_d   = high_q;
    duty_d   = duty_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    locked_d = locked_q;
    case (state_q)
      S_ACQ: begin
        if (rise) begin
          // First edge only aligns the period; nothing is published.
          state_d  = S_HIGH;
          period_d = ONE_C;
          high_d   = ONE_C;
        end else if (fall) begin
          period_d = '0;
        end else if (period_q != TO_C) begin
          // Stable-level count; report the static duty exactly once.
          period_d = period_nxt;
          if (period_nxt == TO_C) begin
            duty_d   = level ? PW_D : '0;
            valid_d  = 1'b1;
            locked_d = 1'b0;
          end
        end
      end
      S_HIGH: begin
        period_d = period_inc;
        high_d   = high_inc;
        if (fall) begin
          state_d = S_LOW;
          high_d  = high_q;
        end else if (period_inc == TO_C) begin
          duty_d   = PW_D;
          valid_d  = 1'b1;
          locked_d = 1'b0;
          state_d  = S_ACQ;
        end
      end
      S_LOW: begin
        period_d = period_inc;
        // Rise is tested first so it wins over a coincident timeout.
        if (rise) begin
          if (period_q >= LO_C && period_q <= HI_C) begin
            duty_d   = high_clamped[DUTY_BITS-1:0];
            valid_d  = 1'b1;
            locked_d = 1'b1;
          end else begin
            err_d    = 1'b1;
            locked_d = 1'b0;
          end
          state_d  = S_HIGH;
          period_d = ONE_C;
          high_d   = ONE_C;
        end else if (period_inc == TO_C) begin
          duty_d   = '0;
          valid_d  = 1'b1;
          locked_d = 1'b0;
          state_d  = S_ACQ;
        end
      end
      default: state_d = S_ACQ;
    endcase
  end

  assign bus.duty_cycle = duty_q;
  assign bus.duty_valid = valid_q;
  assign bus.period_err = err_q;
  assign bus.locked     = locked_q;
endmodule

// File: tb/tb_pwm_deserializer.sv
module tb_pwm_deserializer;
  localparam int PW  = 100;
  localparam int TOL = 2;

  typedef struct {
    bit is_err;
    int duty;
    bit locked;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   cyc;
  int   rel_cyc;
  int   last_valid_cyc;
  exp_t sb[$];

  // Reference model of the transmitted stream.
  bit   have_prev;
  int   prev_h;
  int   prev_p;
  int   last_duty;

  pwm_deserializer_if #(.DUTY_BITS(7)) bus ();

  pwm_deserializer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s got %0d expected %0d", tag, got, want);
    end
  endtask

  // One clock; outputs sampled on the falling edge and strobes scored.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (bus.duty_valid || bus.period_err) begin
      if (bus.duty_valid) last_valid_cyc = cyc;
      check("strobe_exclusive", 32'(bus.duty_valid & bus.period_err), 32'd0);
      check("strobe_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("strobe_kind_err", 32'(bus.period_err), 32'(e.is_err));
        check("strobe_duty", 32'(bus.duty_cycle), 32'(e.duty));
        check("strobe_locked", 32'(bus.locked), 32'(e.locked));
      end
    end
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic push(input bit is_err, input int duty, input bit lk);
    exp_t e;
    e.is_err = is_err;
    e.duty   = duty;
    e.locked = lk;
    sb.push_back(e);
  endtask

  // The rise that starts a new period closes the previous one.
  task automatic push_prev();
    if (have_prev) begin
      if (prev_p >= PW - TOL && prev_p <= PW + TOL) begin
        last_duty = (prev_h > PW) ? PW : prev_h;
        push(1'b0, last_duty, 1'b1);
      end else begin
        push(1'b1, last_duty, 1'b0);
      end
    end
  endtask

  task automatic send_period(input int h, input int p);
    push_prev();
    bus.pwm_in = 1'b1;
    run(h);
    bus.pwm_in = 1'b0;
    run(p - h);
    have_prev = 1'b1;
    prev_h    = h;
    prev_p    = p;
  endtask

  task automatic hold_level(input bit v, input int n);
    if (v) push_prev();
    last_duty = v ? PW : 0;
    push(1'b0, last_duty, 1'b0);
    bus.pwm_in = v;
    run(n);
    have_prev = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc = 0;
    last_valid_cyc = -1;
    have_prev = 1'b0;
    prev_h = 0;
    prev_p = 0;
    last_duty = 0;
    reset = 1'b0;
    bus.pwm_in = 1'b0;

    run(3);
    check("rst_duty", 32'(bus.duty_cycle), 32'd0);
    check("rst_valid", 32'(bus.duty_valid), 32'd0);
    check("rst_err", 32'(bus.period_err), 32'd0);
    check("rst_locked", 32'(bus.locked), 32'd0);
    reset = 1'b1;
    rel_cyc = cyc;

    // Constant low from reset: one report of 0 at the 200th stable cycle.
    hold_level(1'b0, 250);
    check("static_low_time", 32'(last_valid_cyc - rel_cyc), 32'd200);
    check("static_low_locked", 32'(bus.locked), 32'd0);

    // Nominal stream, duty 25.
    repeat (5) send_period(25, 100);
    check("lock_after_stream", 32'(bus.locked), 32'd1);

    // Short periods are rejected, then a slightly long one is accepted.
    send_period(30, 90);
    send_period(30, 90);
    send_period(30, 101);
    check("duty_held_after_err", 32'(bus.duty_cycle), 32'd25);
    check("unlocked_after_err", 32'(bus.locked), 32'd0);

    // Duty change mid-stream.
    send_period(25, 100);
    send_period(75, 100);
    send_period(75, 100);

    // Reset pulse inside a high phase.
    push_prev();
    bus.pwm_in = 1'b1;
    run(10);
    reset = 1'b0;
    tick();
    check("midrst_duty", 32'(bus.duty_cycle), 32'd0);
    check("midrst_valid", 32'(bus.duty_valid), 32'd0);
    check("midrst_err", 32'(bus.period_err), 32'd0);
    check("midrst_locked", 32'(bus.locked), 32'd0);
    reset = 1'b1;
    run(65);
    bus.pwm_in = 1'b0;
    run(25);
    // Resync aligns on the wire still being high; that partial period is too short.
    have_prev = 1'b1;
    prev_h    = 0;
    prev_p    = 0;
    last_duty = 0;
    send_period(25, 100);
    send_period(25, 100);

    // Constant high reports full duty once, then the wire returns low.
    hold_level(1'b1, 250);
    check("static_high_duty", 32'(bus.duty_cycle), 32'd100);
    hold_level(1'b0, 250);
    check("static_low2_duty", 32'(bus.duty_cycle), 32'd0);

    run(10);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pwm_deserializer.md
Name: pwm_deserializer

Overview:
- Receive-side counterpart of the PWM serializer. Samples an incoming PWM wire and recovers its duty cycle as a high-time count per period.
- Sits on the receive side of a board-to-board or loopback PWM link, where a PWMSerializer instance drives the wire. Reports a fresh measurement once per period.
- Also covers 0% and 100% duty (no edges) and checks that the period is valid.

Parameters:
- PULSE_FREQ, 1, expected PWM frequency in MHz (must match the transmitting serializer).
- SYS_FREQ, 100, system clock in MHz (Nexys A7 = 100).
- PERIOD_TOL, 2, allowed deviation of the measured period from PULSE_WINDOW, in clk cycles.
- Derived localparams: PULSE_WINDOW = SYS_FREQ/PULSE_FREQ; TIMEOUT = 2*PULSE_WINDOW; DUTY_BITS = $clog2(PULSE_WINDOW+1); CNT_BITS = $clog2(TIMEOUT+1).

Ports:
- clk, input, 1, system clock; all logic on posedge.
- reset, input, 1, synchronous, active-low: reset==0 at a posedge clk resets the block.
- pwm_in, input, 1, asynchronous PWM wire.
- duty_cycle, output, DUTY_BITS, last accepted high-time count in cycles; 0..PULSE_WINDOW (equals percent at defaults).
- duty_valid, output, 1, one-cycle strobe when duty_cycle updates.
- period_err, output, 1, one-cycle strobe when a period falls outside tolerance.
- locked, output, 1, high while measurements are being accepted.

Behaviour:
- Reset (reset==0 at posedge): duty_cycle=0, duty_valid=0, period_err=0, locked=0, synchronizer flops=0, counters=0, state=S_ACQ.
- Input path: 2-flop synchronizer s1->s2, plus s3 = previous s2. rise = s2&~s3; fall = ~s2&s3.
- Latency: pwm_in first sampled high at clk edge N gives s2=1 after N+1; the FSM acts at edge N+2, and strobes/outputs are visible after edge N+2.
- period_cnt counts cycles since the last accepted rise, saturating at TIMEOUT. high_cnt counts cycles with s2=1 within the current period.
- S_ACQ:
  - rise -> S_HIGH; period_cnt=1, high_cnt=1. No publish (first edge only aligns).
  - s2 stable for TIMEOUT cycles -> go to the static-level reporting below.
- S_HIGH:
  - each cycle increments period_cnt and high_cnt.
  - fall -> S_LOW.
  - period_cnt reaching TIMEOUT -> duty_cycle=PULSE_WINDOW, duty_valid=1, locked=0, state=S_ACQ.
- S_LOW:
  - each cycle increments period_cnt.
  - rise -> check period P = period_cnt.
  - If |P-PULSE_WINDOW| <= PERIOD_TOL: duty_cycle=high_cnt, duty_valid=1, locked=1.
  - Otherwise: period_err=1, locked=0, duty_cycle held.
  - Either way, restart with period_cnt=1, high_cnt=1, state=S_HIGH.
  - period_cnt reaching TIMEOUT -> duty_cycle=0, duty_valid=1, locked=0, state=S_ACQ.
- Static level from S_ACQ: after TIMEOUT stable cycles, report 0 (low) or PULSE_WINDOW (high) once with duty_valid=1. Counter then holds; no repeat until an edge occurs.
- A high pulse of at least 1 cycle is measured as-is. No deglitching beyond the synchronizer.
- Simultaneous rise and timeout in the same cycle: the rise wins (period check applies).
- high_cnt is clamped to PULSE_WINDOW before publishing.
- duty_valid and period_err are never high in the same cycle.
- Reset mid-measurement: the next cycle shows reset values. The first duty_valid requires a fresh aligning rise plus one full period, or a TIMEOUT.

Decomposition:
- Shared pwm_pkg: PULSE_WINDOW/TIMEOUT/width derivations, and the FSM state enum (S_ACQ, S_HIGH, S_LOW), shared with the serializer's parameters.
- One natural sub-module: pwm_edge_sync (2-flop synchronizer + s3, rise/fall outputs, synchronous active-low reset).

Test Plan:
- Serializer driving duty 25 at defaults:
  - after the second rise: duty_cycle=25, duty_valid for 1 cycle, locked=1.
  - repeats every 100 cycles, period_err never asserts.
- Constant low after reset for 250 cycles -> exactly one duty_valid with duty_cycle=0 at the 200th stable cycle; locked=0; no further strobes.
- Constant high (serializer duty >= 100) -> one duty_valid with duty_cycle=100 after 200 cycles.
- Period 90 cycles, high 30 -> period_err strobe each period, duty_cycle holds its previous value (25), locked drops to 0. Period 101 -> accepted.
- Duty changed 25 -> 75 mid-stream -> the next strobe shows 25 or 75 (never another value); the following strobe shows 75.
- reset=0 for 1 cycle during S_HIGH -> all outputs 0 next cycle; no duty_valid until 2 rises later (about 100-200 cycles).
